cfa_blend_mix: RTL and testbench



---
 rtl/cfa_pkg.sv | 31 +++
 rtl/cfa_div255_rnd.sv | 31 +++
 rtl/cfa_blend_mix.sv | 154 +++++++++++++++
 tb/tb_cfa_blend_mix.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// -----------------------------------------------------------------------------
// cfa_pkg
// Shared constants for the CFA demosaic gradient-weight path. The blend mixer
// and the weight generator (and its verification model) both use it.
//   PIX_W / WGT_W   : pixel and weight widths
//   PROD_W / SUM_W  : width of one weighted product, and of the sum of two
//   W_MAX           : full-scale weight (pixel a only)
//   HALF            : rounding bias for round-half-up division by 255
//   DIV_MUL/SHIFT   : reciprocal constant for exact floor(x/255), x <= 65152
// -----------------------------------------------------------------------------
package cfa_pkg;

  localparam int PIX_W  = 8;
  localparam int WGT_W  = 8;
  localparam int PROD_W = 2 * PIX_W;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [WGT_W-1:0] W_MAX = 8'd255;
  localparam logic [SUM_W-1:0] HALF  = 17'd127;

  // ceil(2^23 / 255). For x <= 65152 the overshoot is below 1/255 minus the
  // largest fractional part of x/255, so (x * DIV_MUL) >> 23 == floor(x/255).
  localparam logic [15:0] DIV_MUL   = 16'd32897;
  localparam int          DIV_SHIFT = 23;

  // True when the weight selects pixel a alone.
  function automatic logic is_full_weight(input logic [WGT_W-1:0] wt);
    return (wt == W_MAX);
  endfunction

endpackage

// File: rtl/cfa_div255_rnd.sv
// -----------------------------------------------------------------------------
// cfa_div255_rnd
// Combinational round-half-up division by 255: q = floor((s + 127) / 255).
// Exact for every s in 0..65025, the range of a*w + b*(255-w).
// Ports:
//   s : in  17-bit weighted sum
//   q : out 8-bit rounded quotient
// -----------------------------------------------------------------------------
module cfa_div255_rnd
  import cfa_pkg::*;
(
  input  logic [SUM_W-1:0] s,
  output logic [PIX_W-1:0] q
);

  logic [SUM_W-1:0]    biased_s;
  logic [SUM_W+15:0]   prod_s;
  logic                unused_s;

  // Bias for rounding, then multiply by the scaled reciprocal of 255.
  always_comb begin
    biased_s = s + HALF;
    prod_s   = {16'd0, biased_s} * {{SUM_W{1'b0}}, DIV_MUL};
  end

  assign q = prod_s[DIV_SHIFT +: PIX_W];

  // Fraction bits and the always-zero top bits carry no information.
  assign unused_s = ^{prod_s[SUM_W+15:DIV_SHIFT+PIX_W], prod_s[DIV_SHIFT-1:0]};

endmodule

// File: rtl/cfa_blend_mix.sv
// -----------------------------------------------------------------------------
// cfa_blend_mix
// Blends two interpolated CFA pixels by a normalised weight:
//   pix_out = round((a*w + b*(255-w)) / 255)
// through a 3-stage valid/ready pipeline (S1 products, S2 sum, S3 divide).
// All stages advance together when the output is empty or being taken.
// Optional build macro CFA_BLEND_CNT_EN adds handshake counters.
// Ports:
//   clk        : in  rising-edge clock
//   rst        : in  asynchronous active-low reset
//   in_valid   : in  input beat valid
//   in_ready   : out block accepts a beat this cycle (combinational)
//   pix_a      : in  pixel at full weight
//   pix_b      : in  pixel at zero weight
//   w          : in  blend weight 0..255
//   out_valid  : out pix_out valid
//   out_ready  : in  downstream accepts pix_out
//   pix_out    : out blended pixel
//   pix_cnt    : out (CFA_BLEND_CNT_EN) output handshakes, wrapping 16 bits
//   sat_cnt    : out (CFA_BLEND_CNT_EN) handshakes whose weight was 255
// -----------------------------------------------------------------------------
module cfa_blend_mix
  import cfa_pkg::*;
#(
  parameter int DW = PIX_W,
  parameter int WW = WGT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] pix_a,
  input  logic [DW-1:0] pix_b,
  input  logic [WW-1:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] pix_out
`ifdef CFA_BLEND_CNT_EN
  ,
  output logic [15:0]   pix_cnt,
  output logic [15:0]   sat_cnt
`endif
);

  localparam int            PW    = 2 * DW;
  localparam int            SW    = PW + 1;
  localparam logic [WW-1:0] WFULL = {WW{1'b1}};

  logic          adv_s;
  logic          out_hs_s;
  logic [WW-1:0] w_inv_s;
  logic [DW-1:0] pix_s;

  logic          v1_r;
  logic [PW-1:0] pa_r;
  logic [PW-1:0] pb_r;
  logic          v2_r;
  logic [SW-1:0] sum_r;
  logic          out_valid_r;
  logic [DW-1:0] pix_r;

  // Pipeline enable, output handshake and complementary weight.
  always_comb begin
    adv_s    = !out_valid_r || out_ready;
    out_hs_s = out_valid_r && out_ready;
    w_inv_s  = WFULL - w;
  end

  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign pix_out   = pix_r;

  // S1: weighted products. Data may load on bubbles; v1 marks real beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r <= 1'b0;
      pa_r <= '0;
      pb_r <= '0;
    end else if (adv_s) begin
      v1_r <= in_valid;
      pa_r <= PW'(pix_a) * PW'(w);
      pb_r <= PW'(pix_b) * PW'(w_inv_s);
    end
  end

  // S2: sum of products, at most 255*255 so one extra bit is enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r  <= 1'b0;
      sum_r <= '0;
    end else if (adv_s) begin
      v2_r  <= v1_r;
      sum_r <= SW'(pa_r) + SW'(pb_r);
    end
  end

  cfa_div255_rnd u_div (
    .s (sum_r),
    .q (pix_s)
  );

  // S3: rounded quotient and output valid; a taken output with nothing
  // behind it drops out_valid because v2 is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      pix_r       <= '0;
    end else if (adv_s) begin
      out_valid_r <= v2_r;
      pix_r       <= pix_s;
    end
  end

`ifdef CFA_BLEND_CNT_EN
  logic sat1_r;
  logic sat2_r;
  logic sat3_r;
  logic [15:0] pix_cnt_r;
  logic [15:0] sat_cnt_r;

  // Carry the full-weight flag alongside the data so it leaves with its beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat1_r <= 1'b0;
      sat2_r <= 1'b0;
      sat3_r <= 1'b0;
    end else if (adv_s) begin
      sat1_r <= is_full_weight(w);
      sat2_r <= sat1_r;
      sat3_r <= sat2_r;
    end
  end

  // Handshake counters; 16-bit adds wrap 65535 -> 0 naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_r <= 16'd0;
      sat_cnt_r <= 16'd0;
    end else if (out_hs_s) begin
      pix_cnt_r <= pix_cnt_r + 16'd1;
      if (sat3_r) begin
        sat_cnt_r <= sat_cnt_r + 16'd1;
      end
    end
  end

  assign pix_cnt = pix_cnt_r;
  assign sat_cnt = sat_cnt_r;
`else
  logic unused_hs_s;
  assign unused_hs_s = out_hs_s;
`endif

endmodule

// File: tb/tb_cfa_blend_mix.sv
// -----------------------------------------------------------------------------
// tb_cfa_blend_mix
// Directed and randomized checks of cfa_blend_mix against an arithmetic
// reference: expected pixel = (a*w + b*(255-w) + 127) / 255, queued in
// acceptance order and compared on every output handshake.
// -----------------------------------------------------------------------------
module tb_cfa_blend_mix;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pix_a;
  logic [7:0] pix_b;
  logic [7:0] w;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pix_out;
`ifdef CFA_BLEND_CNT_EN
  logic [15:0] pix_cnt;
  logic [15:0] sat_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  bit mdl_on     = 1'b0;
  int acc_cnt    = 0;
  int hs_cnt     = 0;

  always #5 clk = ~clk;

  cfa_blend_mix dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_out   (pix_out)
`ifdef CFA_BLEND_CNT_EN
    ,
    .pix_cnt   (pix_cnt),
    .sat_cnt   (sat_cnt)
`endif
  );

  function automatic int ref_blend(input int a, input int b, input int wt);
    return (a * wt + b * (255 - wt) + 127) / 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, score the handshakes that
  // the next rising edge will perform, then return at the next falling edge.
  task automatic cycle(input bit v, input int a, input int b, input int wt, input bit rdy);
    int got;
    in_valid  = v;
    pix_a     = a[7:0];
    pix_b     = b[7:0];
    w         = wt[7:0];
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (mdl_on) begin
        chk("out_has_model_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("stream_pix", 32'(pix_out), 32'(got));
        end
      end
    end
    if (in_valid && in_ready) begin
      acc_cnt++;
      if (mdl_on) exp_q.push_back(ref_blend(a, b, wt));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single beat into an empty pipeline: valid after the third edge, not before.
  task automatic single(input string tag, input int a, input int b, input int wt, input int exp);
    cycle(1'b1, a, b, wt, 1'b1);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    cycle(1'b0, 0, 0, 0, 1'b1);
    chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    cycle(1'b0, 0, 0, 0, 1'b1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pix"}, 32'(pix_out), 32'(exp));
    cycle(1'b0, 0, 0, 0, 1'b1);
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pa, pb, pw;
    bit pv;
    int base;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pix_a     = 8'd0;
    pix_b     = 8'd0;
    w         = 8'd0;
    rst       = 1'b1;
    #1 rst    = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_pix_out", 32'(pix_out), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Directed values and endpoints.
    single("mid", 200, 100, 128, 150);
    single("w255", 37, 201, 255, 37);
    single("w0", 37, 201, 0, 201);
    single("half", 255, 0, 128, 128);
    single("round_up", 1, 0, 128, 1);
    single("a_eq_b", 93, 93, 41, 93);

    // Exhaustive weight sweep, back-to-back.
    mdl_on  = 1'b1;
    acc_cnt = 0;
    for (int a = 0; a <= 255; a += 17) begin
      for (int wt = 0; wt < 256; wt++) begin
        cycle(1'b1, a, 255 - a, wt, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 0, 1'b1);
    chk("sweep_accepted", 32'(acc_cnt), 32'd4096);
    chk("sweep_drained", 32'(exp_q.size()), 32'd0);
    chk("sweep_idle", 32'(out_valid), 32'd0);

    // Backpressure: three beats, six stalled clocks, then release.
    cycle(1'b1, 10, 0, 255, 1'b1);
    cycle(1'b1, 20, 0, 255, 1'b1);
    cycle(1'b1, 30, 0, 255, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pix", 32'(pix_out), 32'd10);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, 99, 0, 255, 1'b0);
    end
    chk("bp_rel_valid0", 32'(out_valid), 32'd1);
    cycle(1'b1, 99, 0, 255, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rel_valid", 32'(out_valid), 32'd1);
      cycle(1'b0, 0, 0, 0, 1'b1);
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Randomized traffic with random backpressure; upstream holds stalled beats.
    pv = 1'b0; pa = 0; pb = 0; pw = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pa = $urandom_range(0, 255);
        pb = ($urandom_range(0, 7) == 0) ? pa : $urandom_range(0, 255);
        case ($urandom_range(0, 5))
          0:       pw = 0;
          1:       pw = 255;
          default: pw = $urandom_range(0, 255);
        endcase
      end
      base = acc_cnt;
      cycle(pv, pa, pb, pw, ($urandom_range(0, 3) != 0));
      if (acc_cnt != base) pv = 1'b0;
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 0, 0, 0, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset while beats are in flight.
    mdl_on = 1'b0;
    cycle(1'b1, 50, 0, 255, 1'b0);
    cycle(1'b1, 60, 0, 255, 1'b0);
    cycle(1'b1, 70, 0, 255, 1'b0);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_pix", 32'(pix_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    single("post_rst", 77, 0, 255, 77);

`ifdef CFA_BLEND_CNT_EN
    // Counters: reset, then 70000 handshakes with five full-weight beats.
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_reset_pix", 32'(pix_cnt), 32'd0);
    chk("cnt_reset_sat", 32'(sat_cnt), 32'd0);
    rst = 1'b1;
    mdl_on = 1'b1;
    hs_cnt = 0;
    base   = 0;
    for (int i = 0; i < 70000; i++) begin
      if (i == 100 || i == 20000 || i == 40000 || i == 60000 || i == 69990) begin
        pw = 255;
        base++;
      end else begin
        pw = $urandom_range(0, 254);
      end
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), pw, 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 0, 1'b1);
    chk("cnt_handshakes", 32'(hs_cnt), 32'd70000);
    chk("cnt_pix", 32'(pix_cnt), 32'(hs_cnt % 65536));
    chk("cnt_pix_wrapped", 32'(pix_cnt), 32'd4464);
    chk("cnt_sat", 32'(sat_cnt), 32'(base));
    chk("cnt_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
